// File: rtl/mdu_hilo_pkg.sv
// Shared definitions for the mdu_hilo multiply/divide unit: op codes, FSM states,
// divide-by-zero LO value and small op-decode helpers.
package mdu_hilo_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } mdu_state_t;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  function automatic logic op_is_div(input mdu_op_t op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input mdu_op_t op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the unsigned multiply/divide datapath: shift-add for multiply,
// restoring subtract for divide. acc holds {upper, lower} halves.
module mdu_step
  import mdu_hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  mdu_op_t              op,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_diff;

  always_comb begin
    // Multiply: multiplier sits in the low half and shifts out LSB first.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    // Divide: shift the dividend MSB into the partial remainder, then trial-subtract.
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_diff = rem_sh[WIDTH-1:0] - operand;
    acc_next = {mul_sum, acc[WIDTH-1:1]};
    if (op_is_div(op)) begin
      if (rem_sh >= {1'b0, operand}) begin
        acc_next = {rem_diff, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Define MDU_FAST_MUL_EN to complete multiplies in one cycle via a direct multiplier.
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HI_W,
  input  logic             LO_W,
  input  logic [WIDTH-1:0] W_data,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(ITER + 1);

  mdu_state_t         state_reg;
  mdu_op_t            op_reg;
  mdu_op_t            op_in;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opnd_reg;
  logic [WIDTH-1:0]   a_orig_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic [CW-1:0]      cnt_reg;
  logic               neg_q_reg;
  logic               neg_r_reg;
  logic               div0_reg;
  logic               busy_reg;
  logic               done_reg;

  logic               sgn_in;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    op_in    = mdu_op_t'(Op);
    sgn_in   = op_is_signed(op_in);
    a_mag    = (sgn_in && A[WIDTH-1]) ? -A : A;
    b_mag    = (sgn_in && B[WIDTH-1]) ? -B : B;
    prod_fix = neg_q_reg ? -acc_reg : acc_reg;
    quo_fix  = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    rem_fix  = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
  end

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .op       (op_reg),
    .acc      (acc_reg),
    .operand  (opnd_reg),
    .acc_next (acc_next)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= S_IDLE;
      op_reg     <= OP_MULT;
      acc_reg    <= '0;
      opnd_reg   <= '0;
      a_orig_reg <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      cnt_reg    <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      div0_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (Start) begin
            // Operate on magnitudes; signs are restored in FIX.
            op_reg     <= op_in;
            a_orig_reg <= A;
            opnd_reg   <= b_mag;
            cnt_reg    <= '0;
            neg_q_reg  <= sgn_in & (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r_reg  <= sgn_in & A[WIDTH-1];
            div0_reg   <= op_is_div(op_in) && (B == '0);
`ifdef MDU_FAST_MUL_EN
            if (!op_is_div(op_in)) begin
              acc_reg   <= {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
              state_reg <= S_FIX;
            end else begin
              acc_reg   <= {{WIDTH{1'b0}}, a_mag};
              state_reg <= S_RUN;
              busy_reg  <= 1'b1;
            end
`else
            acc_reg   <= {{WIDTH{1'b0}}, a_mag};
            state_reg <= S_RUN;
            busy_reg  <= 1'b1;
`endif
          end else begin
            if (HI_W) hi_reg <= W_data;
            if (LO_W) lo_reg <= W_data;
          end
        end
        S_RUN: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(ITER - 1)) state_reg <= S_FIX;
        end
        S_FIX: begin
          if (op_is_div(op_reg)) begin
            if (div0_reg) begin
              hi_reg <= a_orig_reg;
              lo_reg <= WIDTH'(DIV0_LO);
            end else begin
              hi_reg <= rem_fix;
              lo_reg <= quo_fix;
            end
          end else begin
            {hi_reg, lo_reg} <= prod_fix;
          end
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign Busy = busy_reg;
  assign Done = done_reg;
  assign HI   = hi_reg;
  assign LO   = lo_reg;

endmodule
